// File: rtl/mmu_xlate_sched.sv
// mmu_xlate_sched
//   Translation scheduler between the IF/MEM stages and the shared TLB.
//   Arbitrates fetch (id 0) and load/store (id 1) requests round-robin.
//   Resolves direct mode and the DMW0/DMW1 windows locally. All other
//   addresses go through one TLB search with a fixed TLB_LAT latency.
//   Only one translation is in flight at a time.
//
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   flush                aborts queued or in-flight work
//   req_*                two requesters; req_ready is a one-hot accept
//   csr_*                CRMD/DMW state, latched at accept
//   tlb_s_*              one-cycle search strobe and vpn2/odd fields
//   tlb_*                TLB result, valid TLB_LAT cycles after the strobe
//   resp_*               registered response with valid/ready handshake
//   perf_lookup/miss     search and TLBR counters
//
// Build option
//   MMU_PERF_CNT_EN      when defined, builds the perf counters; otherwise
//                        perf_lookup/perf_miss are tied to 0
//
// state  | meaning
// IDLE   | waiting for a request, grant made combinationally
// SEARCH | TLB search issued, counting to TLB_LAT
// RESP   | response held until consumed or flushed
// DRAIN  | flushed search, waiting out the TLB latency
module mmu_xlate_sched #(
  parameter int TLB_LAT = 1,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [31:0]      req_vaddr0,
  input  logic [31:0]      req_vaddr1,
  input  logic             req_store1,
  input  logic             csr_da,
  input  logic             csr_pg,
  input  logic [1:0]       csr_datf,
  input  logic [1:0]       csr_datm,
  input  logic [1:0]       csr_plv,
  input  logic [31:0]      csr_dmw0,
  input  logic [31:0]      csr_dmw1,
  output logic             tlb_s_valid,
  output logic [18:0]      tlb_s_vpn2,
  output logic             tlb_s_odd,
  input  logic             tlb_found,
  input  logic [19:0]      tlb_pfn,
  input  logic             tlb_v,
  input  logic             tlb_d,
  input  logic [1:0]       tlb_plv,
  input  logic [1:0]       tlb_mat,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [31:0]      resp_paddr,
  output logic [1:0]       resp_mat,
  output logic             resp_exc,
  output logic [5:0]       resp_ecode,
  output logic [CNT_W-1:0] perf_lookup,
  output logic [CNT_W-1:0] perf_miss
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  localparam logic [2:0] LAT = 3'(TLB_LAT);

  logic [1:0]  r_state;
  logic [2:0]  r_cnt;
  logic        r_rr_last;
  logic [31:0] r_vaddr;
  logic        r_id;
  logic        r_store;
  logic [1:0]  r_plv;
  logic        r_resp_valid;
  logic        r_resp_id;
  logic [31:0] r_resp_paddr;
  logic [1:0]  r_resp_mat;
  logic        r_resp_exc;
  logic [5:0]  r_resp_ecode;

  logic        w_gnt;
  logic        w_gnt_id;
  logic [31:0] w_vaddr;
  logic        w_direct;
  logic        w_dmw0_hit;
  logic        w_dmw1_hit;
  logic        w_local;
  logic [31:0] w_local_paddr;
  logic [1:0]  w_local_mat;
  logic        w_tlb_exc;
  logic [5:0]  w_tlb_ecode;
  logic        w_lat_hit;
  logic        w_strobe;

  always_comb begin
    w_gnt    = 1'b0;
    w_gnt_id = 1'b0;
    if (r_state == S_IDLE && !flush) begin
      case (req_valid)
        2'b01: begin w_gnt = 1'b1; w_gnt_id = 1'b0;       end
        2'b10: begin w_gnt = 1'b1; w_gnt_id = 1'b1;       end
        2'b11: begin w_gnt = 1'b1; w_gnt_id = ~r_rr_last; end
        default: ;
      endcase
    end
  end

  assign req_ready = w_gnt ? (w_gnt_id ? 2'b10 : 2'b01) : 2'b00;

  assign w_vaddr    = w_gnt_id ? req_vaddr1 : req_vaddr0;
  assign w_direct   = csr_da & ~csr_pg;
  assign w_dmw0_hit = (csr_dmw0[31:29] == w_vaddr[31:29]) && csr_dmw0[csr_plv];
  assign w_dmw1_hit = (csr_dmw1[31:29] == w_vaddr[31:29]) && csr_dmw1[csr_plv];
  assign w_local    = w_direct | w_dmw0_hit | w_dmw1_hit;

  always_comb begin
    w_local_paddr = w_vaddr;
    w_local_mat   = w_gnt_id ? csr_datm : csr_datf;
    if (!w_direct) begin
      if (w_dmw0_hit) begin
        w_local_paddr = {csr_dmw0[27:25], w_vaddr[28:0]};
        w_local_mat   = csr_dmw0[5:4];
      end else begin
        w_local_paddr = {csr_dmw1[27:25], w_vaddr[28:0]};
        w_local_mat   = csr_dmw1[5:4];
      end
    end
  end

  always_comb begin
    w_tlb_exc   = 1'b1;
    w_tlb_ecode = 6'h00;
    if (!tlb_found)                w_tlb_ecode = 6'h3F;
    else if (!tlb_v)               w_tlb_ecode = !r_id ? 6'h03 : (r_store ? 6'h02 : 6'h01);
    else if (r_plv > tlb_plv)      w_tlb_ecode = 6'h07;
    else if (r_store && !tlb_d)    w_tlb_ecode = 6'h04;
    else                           w_tlb_exc   = 1'b0;
  end

  assign w_lat_hit = (r_cnt == LAT);
  assign w_strobe  = (r_state == S_SEARCH) && (r_cnt == 3'd0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_cnt        <= 3'd0;
      r_rr_last    <= 1'b1;
      r_vaddr      <= 32'd0;
      r_id         <= 1'b0;
      r_store      <= 1'b0;
      r_plv        <= 2'd0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= 1'b0;
      r_resp_paddr <= 32'd0;
      r_resp_mat   <= 2'd0;
      r_resp_exc   <= 1'b0;
      r_resp_ecode <= 6'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt) begin
            r_vaddr   <= w_vaddr;
            r_id      <= w_gnt_id;
            r_store   <= w_gnt_id & req_store1;
            r_plv     <= csr_plv;
            r_rr_last <= w_gnt_id;
            r_cnt     <= 3'd0;
            if (w_local) begin
              r_resp_valid <= 1'b1;
              r_resp_id    <= w_gnt_id;
              r_resp_paddr <= w_local_paddr;
              r_resp_mat   <= w_local_mat;
              r_resp_exc   <= 1'b0;
              r_resp_ecode <= 6'd0;
              r_state      <= S_RESP;
            end else begin
              r_state <= S_SEARCH;
            end
          end
        end
        S_SEARCH: begin
          r_cnt <= r_cnt + 3'd1;
          if (flush) begin
            r_state <= S_DRAIN;
          end else if (w_lat_hit) begin
            r_resp_valid <= 1'b1;
            r_resp_id    <= r_id;
            r_resp_paddr <= w_tlb_exc ? 32'd0 : {tlb_pfn, r_vaddr[11:0]};
            r_resp_mat   <= w_tlb_exc ? 2'd0 : tlb_mat;
            r_resp_exc   <= w_tlb_exc;
            r_resp_ecode <= w_tlb_ecode;
            r_state      <= S_RESP;
          end
        end
        // A flush landing on the result cycle enters here with cnt past
        // LAT; the >= lets it leave immediately.
        S_DRAIN: begin
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt >= LAT) r_state <= S_IDLE;
        end
        default: begin
          if (flush || resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign tlb_s_valid = w_strobe;
  assign tlb_s_vpn2  = r_vaddr[31:13];
  assign tlb_s_odd   = r_vaddr[12];
  assign resp_valid  = r_resp_valid;
  assign resp_id     = r_resp_id;
  assign resp_paddr  = r_resp_paddr;
  assign resp_mat    = r_resp_mat;
  assign resp_exc    = r_resp_exc;
  assign resp_ecode  = r_resp_ecode;

`ifdef MMU_PERF_CNT_EN
  logic [CNT_W-1:0] r_perf_lookup;
  logic [CNT_W-1:0] r_perf_miss;

  // Misses are counted whenever a result is on the bus, drained or not.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_perf_lookup <= '0;
      r_perf_miss   <= '0;
    end else begin
      if (w_strobe) r_perf_lookup <= r_perf_lookup + CNT_W'(1);
      if ((r_state == S_SEARCH || r_state == S_DRAIN) && w_lat_hit && !tlb_found)
        r_perf_miss <= r_perf_miss + CNT_W'(1);
    end
  end

  assign perf_lookup = r_perf_lookup;
  assign perf_miss   = r_perf_miss;
`else
  assign perf_lookup = '0;
  assign perf_miss   = '0;
`endif

  // DMW bits outside VSEG/PSEG/MAT/PLV carry nothing for translation.
  logic w_unused;
  assign w_unused = ^{csr_dmw0[28], csr_dmw0[24:6], csr_dmw1[28], csr_dmw1[24:6]};

endmodule

// File: tb/tb_mmu_xlate_sched.sv
module tb_mmu_xlate_sched;
  localparam int LAT = 2;

  logic        clk, resetn, flush;
  logic [1:0]  req_valid, req_ready;
  logic [31:0] req_vaddr0, req_vaddr1;
  logic        req_store1;
  logic        csr_da, csr_pg;
  logic [1:0]  csr_datf, csr_datm, csr_plv;
  logic [31:0] csr_dmw0, csr_dmw1;
  logic        tlb_s_valid;
  logic [18:0] tlb_s_vpn2;
  logic        tlb_s_odd;
  logic        tlb_found, tlb_v, tlb_d;
  logic [19:0] tlb_pfn;
  logic [1:0]  tlb_plv, tlb_mat;
  logic        resp_valid, resp_ready, resp_id, resp_exc;
  logic [31:0] resp_paddr;
  logic [1:0]  resp_mat;
  logic [5:0]  resp_ecode;
  logic [31:0] perf_lookup, perf_miss;

  mmu_xlate_sched #(.TLB_LAT(LAT), .CNT_W(32)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_vaddr0(req_vaddr0), .req_vaddr1(req_vaddr1), .req_store1(req_store1),
    .csr_da(csr_da), .csr_pg(csr_pg), .csr_datf(csr_datf), .csr_datm(csr_datm),
    .csr_plv(csr_plv), .csr_dmw0(csr_dmw0), .csr_dmw1(csr_dmw1),
    .tlb_s_valid(tlb_s_valid), .tlb_s_vpn2(tlb_s_vpn2), .tlb_s_odd(tlb_s_odd),
    .tlb_found(tlb_found), .tlb_pfn(tlb_pfn), .tlb_v(tlb_v), .tlb_d(tlb_d),
    .tlb_plv(tlb_plv), .tlb_mat(tlb_mat),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_paddr(resp_paddr), .resp_mat(resp_mat), .resp_exc(resp_exc),
    .resp_ecode(resp_ecode),
    .perf_lookup(perf_lookup), .perf_miss(perf_miss)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        id;
    logic [31:0] pa;
    logic [1:0]  mat;
    logic        exc;
    logic [5:0]  ec;
    logic        srch;
  } exp_t;

  typedef struct {
    logic        da, pg;
    logic [1:0]  plv;
    logic [31:0] dmw0, dmw1;
    logic        id;
    logic [31:0] va;
    logic        st;
    logic        fnd;
    logic [19:0] pfn;
    logic        v, d;
    logic [1:0]  tplv, tmat;
    logic [31:0] e_pa;
    logic [1:0]  e_mat;
    logic        e_exc;
    logic [5:0]  e_ec;
    logic        srch;
  } vec_t;

  exp_t        sb[$];
  vec_t        vt[15];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          n_strobe = 0;
  int          last_strobe = 0;
  int          exp_lookups = 0;
  int          exp_miss = 0;
  logic [31:0] exp_s_vaddr = 32'd0;

  // TLB model: real result only in the cycle exactly LAT after the strobe,
  // inverted garbage otherwise.
  logic        m_found, m_v, m_d;
  logic [19:0] m_pfn;
  logic [1:0]  m_plv, m_mat;
  logic [3:0]  pipe;

  always @(posedge clk or negedge resetn)
    if (!resetn) pipe <= 4'd0;
    else         pipe <= {pipe[2:0], tlb_s_valid};

  assign tlb_found = pipe[LAT-1] ? m_found : ~m_found;
  assign tlb_pfn   = pipe[LAT-1] ? m_pfn   : ~m_pfn;
  assign tlb_v     = pipe[LAT-1] ? m_v     : ~m_v;
  assign tlb_d     = pipe[LAT-1] ? m_d     : ~m_d;
  assign tlb_plv   = pipe[LAT-1] ? m_plv   : ~m_plv;
  assign tlb_mat   = pipe[LAT-1] ? m_mat   : ~m_mat;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    #3;
    if (resetn && tlb_s_valid) begin
      n_strobe++;
      last_strobe = cyc;
      check("s_vpn2", {13'd0, tlb_s_vpn2}, {13'd0, exp_s_vaddr[31:13]});
      check("s_odd", {31'd0, tlb_s_odd}, {31'd0, exp_s_vaddr[12]});
    end
  end

  always @(negedge clk) begin
    exp_t e;
    #3;
    if (resetn && resp_valid && resp_ready && !flush) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_resp: got paddr 0x%0h id %0d, expected none", resp_paddr, resp_id);
      end else begin
        e = sb.pop_front();
        check("resp_id", {31'd0, resp_id}, {31'd0, e.id});
        check("resp_paddr", resp_paddr, e.pa);
        check("resp_exc", {31'd0, resp_exc}, {31'd0, e.exc});
        check("resp_ecode", {26'd0, resp_ecode}, {26'd0, e.ec});
        if (!e.exc) check("resp_mat", {30'd0, resp_mat}, {30'd0, e.mat});
        if (e.srch) check("resp_latency", cyc - last_strobe, LAT + 1);
      end
    end
  end

  task automatic do_req(input logic id, input logic [31:0] va, input logic st,
                        input bit push, input exp_t e);
    int t;
    logic [1:0] oh;
    oh = id ? 2'b10 : 2'b01;
    @(negedge clk);
    if (id) req_vaddr1 = va; else req_vaddr0 = va;
    req_store1  = st;
    req_valid   = oh;
    exp_s_vaddr = va;
    t = 0;
    #1;
    while (req_ready !== oh && t < 30) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("grant", {30'd0, req_ready}, {30'd0, oh});
    if (push) sb.push_back(e);
    @(negedge clk);
    req_valid = 2'b00;
  endtask

  task automatic wait_empty();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("sb_drained", sb.size(), 0);
  endtask

  task automatic check_perf(input string nm);
`ifdef MMU_PERF_CNT_EN
    check({nm, "_perf_lookup"}, perf_lookup, exp_lookups);
    check({nm, "_perf_miss"}, perf_miss, exp_miss);
`else
    check({nm, "_perf_lookup"}, perf_lookup, 32'd0);
    check({nm, "_perf_miss"}, perf_miss, 32'd0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e, e0;
    int   g, t, ns, s0;
    logic [1:0] ge;

    //            da pg plv dmw0          dmw1          id va            st fnd pfn       v  d  tplv tmat e_pa          emat exc ec     srch
    vt[0]  = '{1, 0, 0, 32'h0,        32'h0,        0, 32'h1C000000, 0, 0, 20'h0,     0, 0, 0, 0, 32'h1C000000, 2, 0, 6'h00, 0};
    vt[1]  = '{1, 0, 0, 32'h0,        32'h0,        1, 32'h00001234, 1, 0, 20'h0,     0, 0, 0, 0, 32'h00001234, 1, 0, 6'h00, 0};
    vt[2]  = '{0, 1, 0, 32'h90000011, 32'h0,        1, 32'h90001234, 0, 0, 20'h0,     0, 0, 0, 0, 32'h10001234, 1, 0, 6'h00, 0};
    vt[3]  = '{0, 1, 3, 32'h90000011, 32'hA2000028, 0, 32'hA0ABCDEF, 0, 0, 20'h0,     0, 0, 0, 0, 32'h20ABCDEF, 2, 0, 6'h00, 0};
    vt[4]  = '{0, 1, 0, 32'h90000011, 32'h92000031, 1, 32'h80000010, 0, 0, 20'h0,     0, 0, 0, 0, 32'h00000010, 1, 0, 6'h00, 0};
    vt[5]  = '{0, 1, 3, 32'h90000011, 32'h0,        1, 32'h90001234, 0, 1, 20'h12345, 1, 0, 3, 1, 32'h12345234, 1, 0, 6'h00, 1};
    vt[6]  = '{0, 1, 0, 32'h0,        32'h0,        1, 32'h00403ABC, 1, 1, 20'h12345, 1, 1, 0, 1, 32'h12345ABC, 1, 0, 6'h00, 1};
    vt[7]  = '{0, 1, 0, 32'h0,        32'h0,        0, 32'h00010000, 0, 0, 20'h0AAAA, 1, 1, 0, 0, 32'h0,        0, 1, 6'h3F, 1};
    vt[8]  = '{0, 1, 0, 32'h0,        32'h0,        1, 32'h00020000, 1, 1, 20'h11111, 1, 0, 0, 1, 32'h0,        0, 1, 6'h04, 1};
    vt[9]  = '{0, 1, 3, 32'h0,        32'h0,        1, 32'h00030000, 0, 1, 20'h22222, 1, 1, 0, 2, 32'h0,        0, 1, 6'h07, 1};
    vt[10] = '{0, 1, 0, 32'h0,        32'h0,        0, 32'h00040000, 0, 1, 20'h33333, 0, 1, 0, 0, 32'h0,        0, 1, 6'h03, 1};
    vt[11] = '{0, 1, 0, 32'h0,        32'h0,        1, 32'h00041000, 0, 1, 20'h33333, 0, 1, 0, 0, 32'h0,        0, 1, 6'h01, 1};
    vt[12] = '{0, 1, 3, 32'h0,        32'h0,        1, 32'h00042000, 1, 1, 20'h33333, 0, 0, 0, 0, 32'h0,        0, 1, 6'h02, 1};
    vt[13] = '{0, 1, 3, 32'h0,        32'h0,        1, 32'h00043000, 1, 1, 20'h44444, 1, 0, 1, 0, 32'h0,        0, 1, 6'h07, 1};
    vt[14] = '{1, 1, 0, 32'h0,        32'h0,        0, 32'h00050000, 1, 1, 20'h54321, 1, 0, 0, 3, 32'h54321000, 3, 0, 6'h00, 1};

    e0 = '{1'b0, 32'd0, 2'd0, 1'b0, 6'd0, 1'b0};
    resetn = 1'b0; flush = 1'b0; req_valid = 2'b00; req_vaddr0 = 32'd0; req_vaddr1 = 32'd0;
    req_store1 = 1'b0; csr_da = 1'b1; csr_pg = 1'b0; csr_datf = 2'd2; csr_datm = 2'd1;
    csr_plv = 2'd0; csr_dmw0 = 32'd0; csr_dmw1 = 32'd0; resp_ready = 1'b1;
    m_found = 1'b1; m_pfn = 20'd0; m_v = 1'b1; m_d = 1'b1; m_plv = 2'd0; m_mat = 2'd0;

    repeat (3) @(negedge clk);
    check("rst_req_ready", {30'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_s_valid", {31'd0, tlb_s_valid}, 32'd0);
    check("rst_resp_paddr", resp_paddr, 32'd0);
    check("rst_resp_ecode", {26'd0, resp_ecode}, 32'd0);
    check_perf("rst");
    resetn = 1'b1;

    // Round-robin with both requesters held; fetch wins the first tie.
    @(negedge clk);
    req_vaddr0 = 32'h100; req_vaddr1 = 32'h200;
    req_valid = 2'b11;
    g = 0; t = 0;
    while (g < 4 && t < 40) begin
      #1;
      if (req_ready != 2'b00) begin
        ge = (g % 2 == 0) ? 2'b01 : 2'b10;
        check("arb_grant", {30'd0, req_ready}, {30'd0, ge});
        if (ge == 2'b01) e = '{1'b0, 32'h100, 2'd2, 1'b0, 6'd0, 1'b0};
        else             e = '{1'b1, 32'h200, 2'd1, 1'b0, 6'd0, 1'b0};
        sb.push_back(e);
        g++;
      end
      @(negedge clk);
      t++;
    end
    req_valid = 2'b00;
    check("arb_count", g, 4);
    wait_empty();

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      csr_da = vt[i].da; csr_pg = vt[i].pg; csr_plv = vt[i].plv;
      csr_dmw0 = vt[i].dmw0; csr_dmw1 = vt[i].dmw1;
      m_found = vt[i].fnd; m_pfn = vt[i].pfn; m_v = vt[i].v; m_d = vt[i].d;
      m_plv = vt[i].tplv; m_mat = vt[i].tmat;
      ns = n_strobe;
      e = '{vt[i].id, vt[i].e_pa, vt[i].e_mat, vt[i].e_exc, vt[i].e_ec, vt[i].srch};
      do_req(vt[i].id, vt[i].va, vt[i].st, 1'b1, e);
      wait_empty();
      check($sformatf("v%0d_strobes", i), n_strobe - ns, {31'd0, vt[i].srch});
      if (vt[i].srch) exp_lookups++;
      if (vt[i].srch && !vt[i].fnd) exp_miss++;
    end
    check_perf("table");

    // Back-pressure: response held, no new grant, later CSR edits ignored.
    @(negedge clk);
    csr_da = 1'b1; csr_pg = 1'b0; csr_datf = 2'd2; csr_datm = 2'd1;
    resp_ready = 1'b0;
    e = '{1'b0, 32'h1C000000, 2'd2, 1'b0, 6'd0, 1'b0};
    do_req(1'b0, 32'h1C000000, 1'b0, 1'b1, e);
    req_vaddr1 = 32'h00ABC000; req_store1 = 1'b0;
    req_valid = 2'b10;
    csr_datf = 2'd3;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_valid", {31'd0, resp_valid}, 32'd1);
      check("bp_paddr", resp_paddr, 32'h1C000000);
      check("bp_mat", {30'd0, resp_mat}, 32'd2);
      check("bp_no_grant", {30'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    e = '{1'b1, 32'h00ABC000, 2'd1, 1'b0, 6'd0, 1'b0};
    sb.push_back(e);
    resp_ready = 1'b1;
    t = 0;
    #1;
    while (req_ready !== 2'b10 && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("bp_next_grant", {30'd0, req_ready}, 32'd2);
    @(negedge clk);
    req_valid = 2'b00;
    wait_empty();

    // Flush in IDLE blocks the grant.
    @(negedge clk);
    flush = 1'b1; req_valid = 2'b01;
    #1 check("flush_idle_ready", {30'd0, req_ready}, 32'd0);
    @(negedge clk);
    flush = 1'b0; req_valid = 2'b00;

    // Flush in RESP drops the response even with resp_ready high.
    resp_ready = 1'b0;
    do_req(1'b0, 32'h00000040, 1'b0, 1'b0, e0);
    #1 check("fresp_valid_before", {31'd0, resp_valid}, 32'd1);
    flush = 1'b1; resp_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1 check("fresp_valid_after", {31'd0, resp_valid}, 32'd0);

    // Flush on the strobe cycle: drained miss, next search waits out LAT.
    @(negedge clk);
    csr_da = 1'b0; csr_pg = 1'b1; csr_dmw0 = 32'd0; csr_dmw1 = 32'd0; csr_plv = 2'd0;
    m_found = 1'b0;
    do_req(1'b0, 32'h00005000, 1'b0, 1'b0, e0);
    flush = 1'b1;
    #1 check("flush_strobe", {31'd0, tlb_s_valid}, 32'd1);
    @(negedge clk);
    flush = 1'b0;
    s0 = last_strobe;
    exp_lookups++; exp_miss++;
    e = '{1'b0, 32'd0, 2'd0, 1'b1, 6'h3F, 1'b1};
    do_req(1'b0, 32'h00006000, 1'b0, 1'b1, e);
    exp_lookups++; exp_miss++;
    wait_empty();
    check("drain_gap", {31'd0, (last_strobe - s0) >= LAT}, 32'd1);
    check_perf("flush");

    // Asynchronous reset during SEARCH.
    m_found = 1'b1;
    do_req(1'b1, 32'h00007000, 1'b0, 1'b0, e0);
    resetn = 1'b0;
    exp_lookups = 0; exp_miss = 0;
    #1;
    check("rstmid_s_valid", {31'd0, tlb_s_valid}, 32'd0);
    check("rstmid_resp_valid", {31'd0, resp_valid}, 32'd0);
    check_perf("rstmid");
    @(negedge clk);
    resetn = 1'b1;
    repeat (LAT + 3) @(negedge clk);
    check("rstmid_no_resp", {31'd0, resp_valid}, 32'd0);
    csr_da = 1'b1; csr_pg = 1'b0;
    e = '{1'b0, 32'h00008000, 2'd3, 1'b0, 6'd0, 1'b0};
    do_req(1'b0, 32'h00008000, 1'b0, 1'b1, e);
    wait_empty();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mmu_xlate_sched.md
Name: mmu_xlate_sched

Overview:
- Schedules all virtual-to-physical translations for the core.
- Arbitrates between the instruction-fetch port (id 0) and the load/store port (id 1), and resolves direct mode and DMW0/DMW1 windows locally.
- Sequences the shared TLB search port over a fixed multi-cycle latency, then returns a physical address, MAT and exception code per request.
- One translation is in flight at a time; it sits between the IF/MEM stages and the TLB.

Parameters:
TLB_LAT, 1, cycles from TLB search issue to result valid (legal 1..3)
CNT_W, 32, width of the optional performance counters

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
flush  in  1  pipeline flush; aborts queued or in-flight work
req_valid  in  2  request valid, bit0=fetch, bit1=data
req_ready  out  2  one-hot accept, bit per requester
req_vaddr0  in  32  fetch virtual address
req_vaddr1  in  32  data virtual address
req_store1  in  1  data request is a store
csr_da  in  1  CRMD.DA
csr_pg  in  1  CRMD.PG
csr_datf  in  2  CRMD.DATF, direct-mode MAT for fetch
csr_datm  in  2  CRMD.DATM, direct-mode MAT for data
csr_plv  in  2  current privilege level
csr_dmw0  in  32  DMW0
csr_dmw1  in  32  DMW1
tlb_s_valid  out  1  one-cycle search strobe
tlb_s_vpn2  out  19  vaddr[31:13]
tlb_s_odd  out  1  vaddr[12]
tlb_found  in  1  hit; all tlb_* inputs valid TLB_LAT cycles after the strobe
tlb_pfn  in  20  hit PFN
tlb_v  in  1  valid bit
tlb_d  in  1  dirty bit
tlb_plv  in  2  page PLV
tlb_mat  in  2  page MAT
resp_valid  out  1  response valid
resp_ready  in  1  consumer accepts
resp_id  out  1  0=fetch, 1=data
resp_paddr  out  32  physical address; 0 when resp_exc
resp_mat  out  2  memory access type
resp_exc  out  1  exception flag
resp_ecode  out  6  LoongArch Ecode
perf_lookup  out  CNT_W  TLB searches issued
perf_miss  out  CNT_W  TLBR events

Behaviour:
- Reset values: every output 0, state IDLE, rr_last=1 (fetch wins the first tie), counters 0.
- States are IDLE, SEARCH, RESP, DRAIN.

IDLE:
- If flush=1, no grant is made.
- Otherwise, when exactly one req_valid bit is set, that requester is granted. When both are set, the requester other than rr_last is granted.
- req_ready[i]=1 combinationally in the grant cycle. It is 0 in all other states.
- At accept, latch vaddr, id, store (forced 0 for id 0), plv, and the mode decision from the current CSRs.
- Mode decision:
  - Direct (da & ~pg): paddr=vaddr; mat=datf for id 0, datm for id 1.
  - Else if dmw0[31:29]==vaddr[31:29] & dmw0[plv]: paddr={dmw0[27:25],vaddr[28:0]}, mat=dmw0[5:4].
  - Else the same test on dmw1. DMW0 wins when both match.
  - Direct/DMW requests go to RESP the next cycle. Others go to SEARCH.
- rr_last updates to the granted id.

SEARCH:
- In the first cycle, tlb_s_valid=1 with the latched vaddr fields. cnt resets to 0 and increments each cycle.
- When cnt==TLB_LAT, sample the tlb_* inputs and go to RESP.
- Exception priority:
  1. !found -> 0x3F (TLBR)
  2. !v -> 0x3 (PIF) for fetch, 0x1 (PIL) for load, 0x2 (PIS) for store
  3. plv>tlb_plv -> 0x7 (PPI)
  4. store & !d -> 0x4 (PME)
- No exception: paddr={pfn,vaddr[11:0]}, mat=tlb_mat.
- A flush in SEARCH goes to DRAIN; no response is produced.

DRAIN:
- Continue counting until cnt==TLB_LAT, discarding the result, then return to IDLE.
- No new search is issued until the drain completes, so stale TLB results cannot alias.

RESP:
- resp_* are registered and held stable while resp_valid=1 and resp_ready=0.
- resp_valid&resp_ready -> IDLE. The next grant can occur in the cycle after the handshake.
- A flush in RESP deasserts resp_valid the next cycle (the response is dropped) and goes to IDLE, including when resp_ready is also 1.

Other rules:
- CSR changes after accept do not affect an in-flight translation.
- resp_ready is ignored when resp_valid=0.
- A req_valid drop while not granted is legal.
- Async reset mid-operation returns to IDLE immediately. No response is emitted.

Optional Feature:
- MMU_PERF_CNT_EN defined:
  - perf_lookup increments on every tlb_s_valid.
  - perf_miss increments when a TLBR is sampled, including a miss during DRAIN.
  - Both wrap at 2^CNT_W.
- Undefined: no counter flops; perf_lookup and perf_miss are tied to 0.

Test Plan:
- Direct: da=1,pg=0, fetch vaddr 0x1C000000 -> req_ready=2'b01 same cycle, resp next cycle paddr 0x1C000000, mat=datf, no tlb_s_valid.
- DMW: pg=1, dmw0=0x90000011, plv=0, data vaddr 0x90001234 -> paddr 0x10001234, mat=01, id=1.
- TLB hit with TLB_LAT=2: vaddr 0x00403ABC, tlb pfn=0x12345, v=1,d=1 -> tlb_s_vpn2=0x00201, odd=1, resp 3 cycles after strobe cycle+1, paddr 0x12345ABC.
- Exceptions: found=0 -> ecode 0x3F. Store with v=1,d=0 -> 0x4. plv=3, tlb_plv=0 -> 0x7. Fetch with v=0 -> 0x3. paddr=0 in each case.
- Arbitration: both valid for 4 consecutive grants -> ids 0,1,0,1. resp_ready held 0 for 3 cycles -> resp stable and no new grant.
- Flush in SEARCH cycle 1 with TLB_LAT=3 -> no resp_valid, next tlb_s_valid no earlier than 3 cycles after the original strobe. perf_lookup=1 with MMU_PERF_CNT_EN.
